// File: rtl/nanci_pkg.sv
// Shared types and element helpers for the Nanci shearsort mesh PE.
// Elements are packed {addr, data}; data is the sort key, addr breaks ties.
package nanci_pkg;

  localparam int MAX_EW = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    DIR_L    = 3'd0,
    DIR_R    = 3'd1,
    DIR_U    = 3'd2,
    DIR_D    = 3'd3,
    DIR_NONE = 3'd4
  } dir_e;

  function automatic int elem_width(input int aw, input int dw);
    return aw + dw;
  endfunction

  // Helpers work on a zero-extended element so any width up to MAX_EW fits.
  function automatic logic [MAX_EW-1:0] elem_data(input logic [MAX_EW-1:0] e, input int dw);
    return e & ((MAX_EW'(1) << dw) - MAX_EW'(1));
  endfunction

  function automatic logic [MAX_EW-1:0] elem_addr(input logic [MAX_EW-1:0] e, input int dw);
    return e >> dw;
  endfunction

endpackage

// File: rtl/nanci_cx_unit.sv
// Combinational compare-exchange: returns the min or max of two elements,
// ordering by unsigned data with the smaller addr winning "min" on equal data.
module nanci_cx_unit
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  localparam int EW = elem_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic [EW-1:0] own,
  input  logic [EW-1:0] partner,
  input  logic          keep_min,
  output logic [EW-1:0] kept
);

  logic [MAX_EW-1:0] own_data, own_addr, par_data, par_addr;
  logic              own_lt, par_lt;

  always_comb begin
    own_data = elem_data(MAX_EW'(own), DATA_WIDTH);
    own_addr = elem_addr(MAX_EW'(own), DATA_WIDTH);
    par_data = elem_data(MAX_EW'(partner), DATA_WIDTH);
    par_addr = elem_addr(MAX_EW'(partner), DATA_WIDTH);

    own_lt = (own_data < par_data) || ((own_data == par_data) && (own_addr < par_addr));
    par_lt = (par_data < own_data) || ((par_data == own_data) && (par_addr < own_addr));

    // Fully equal elements satisfy neither strict test, so own is kept.
    kept = own;
    if (keep_min ? par_lt : own_lt) kept = partner;
  end

endmodule

// File: rtl/nanci_pe_shear.sv
// One PE of a SQRT_N x SQRT_N mesh running a full shearsort after a start.
// Optional NANCI_PE_SWAP_COUNT_EN adds a saturating o_swaps exchange counter.
//
// state | meaning
// IDLE  | accepts i_load / i_start
// ROW   | snake-order row phase (even phase index)
// COL   | ascending column phase (odd phase index)
// DONE  | single-cycle o_done pulse, then IDLE
module nanci_pe_shear
  import nanci_pkg::*;
#(
  parameter int SQRT_N     = 4,
  parameter int I          = 0,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int PHASES     = 5,
  parameter int STEP_W     = 8,
  localparam int EW = elem_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [EW-1:0] i_elem,
  input  logic          i_start,
  input  logic [EW-1:0] i_PE_l,
  input  logic [EW-1:0] i_PE_r,
  input  logic [EW-1:0] i_PE_u,
  input  logic [EW-1:0] i_PE_d,
  output logic [EW-1:0] o_PE,
  output logic          o_busy,
  output logic          o_done
`ifdef NANCI_PE_SWAP_COUNT_EN
  ,
  output logic [STEP_W-1:0] o_swaps
`endif
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_ROW  = 2'(ST_ROW);
  localparam logic [1:0] S_COL  = 2'(ST_COL);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  localparam int ROW_IDX = I / SQRT_N;
  localparam int COL_IDX = I % SQRT_N;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(SQRT_N - 1);
  localparam logic [STEP_W-1:0] LAST_PHASE = STEP_W'(PHASES - 1);

  // Mesh-edge and parity facts are fixed by position, so fold them to constants.
  localparam logic ROW_LO  = 1'(COL_IDX == 0);
  localparam logic ROW_HI  = 1'(COL_IDX == SQRT_N - 1);
  localparam logic COL_LO  = 1'(ROW_IDX == 0);
  localparam logic COL_HI  = 1'(ROW_IDX == SQRT_N - 1);
  localparam logic ROW_PAR = 1'(COL_IDX % 2);
  localparam logic COL_PAR = 1'(ROW_IDX % 2);
  localparam logic ROW_ASC = 1'((ROW_IDX % 2) == 0);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] phase_q, phase_d;
  logic [EW-1:0]     elem_q, elem_d;

  logic          is_row, is_col, go_plus, keep_min;
  dir_e          dir;
  logic [EW-1:0] partner, kept;

  always_comb begin
    is_row  = (state_q == S_ROW);
    is_col  = (state_q == S_COL);
    go_plus = ~((is_row ? ROW_PAR : COL_PAR) ^ step_q[0]);

    dir = DIR_NONE;
    if (is_row) begin
      if (go_plus) dir = ROW_HI ? DIR_NONE : DIR_R;
      else         dir = ROW_LO ? DIR_NONE : DIR_L;
    end else if (is_col) begin
      if (go_plus) dir = COL_HI ? DIR_NONE : DIR_D;
      else         dir = COL_LO ? DIR_NONE : DIR_U;
    end

    // Ascending keeps min toward +1, max toward -1; descending inverts.
    keep_min = ((is_row ? ROW_ASC : 1'b1) == go_plus);

    unique case (dir)
      DIR_L:   partner = i_PE_l;
      DIR_R:   partner = i_PE_r;
      DIR_U:   partner = i_PE_u;
      DIR_D:   partner = i_PE_d;
      default: partner = elem_q;
    endcase
  end

  nanci_cx_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cx (
    .own      (elem_q),
    .partner  (partner),
    .keep_min (keep_min),
    .kept     (kept)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    elem_d  = elem_q;
    case (state_q)
      S_IDLE: begin
        if (i_load) elem_d = i_elem;
        if (i_start) begin
          state_d = S_ROW;
          step_d  = '0;
          phase_d = '0;
        end
      end
      S_ROW, S_COL: begin
        elem_d = kept;
        if (step_q == LAST_STEP) begin
          step_d = '0;
          if (phase_q == LAST_PHASE) begin
            state_d = S_DONE;
          end else begin
            phase_d = phase_q + STEP_W'(1);
            state_d = phase_d[0] ? S_COL : S_ROW;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      phase_q <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      elem_q  <= elem_d;
    end
  end

  assign o_PE   = elem_q;
  assign o_busy = is_row | is_col;
  assign o_done = (state_q == S_DONE);

`ifdef NANCI_PE_SWAP_COUNT_EN
  logic [STEP_W-1:0] swaps_q, swaps_d;

  always_comb begin
    swaps_d = swaps_q;
    if ((state_q == S_IDLE) && i_start) begin
      swaps_d = '0;
    end else if (o_busy && (elem_d != elem_q) && (swaps_q != '1)) begin
      swaps_d = swaps_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) swaps_q <= '0;
    else      swaps_q <= swaps_d;
  end

  assign o_swaps = swaps_q;
`endif

endmodule

// File: tb/tb_nanci_pe_shear.sv
// Bench for nanci_pe_shear: directed corner cases on small meshes plus
// randomized full sorts on a 4x4 interior PE checked against a rule-level model.
module tb_nanci_pe_shear;

  localparam int M_N   = 4;
  localparam int M_I   = 6;
  localparam int M_ROW = M_I / M_N;
  localparam int M_COL = M_I % M_N;
  localparam int M_PH  = 5;
  localparam int M_K   = M_PH * M_N;

  logic       clk;
  logic       rst_n;
  logic [3:0] ld, st;
  logic [5:0] elem, pl, pr, pu, pd;
  wire  [5:0] pe0, pe1, pe2, pe3;
  wire  [3:0] busy, done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NANCI_PE_SWAP_COUNT_EN
  wire [7:0] sw0, sw1, sw2, sw3;
`endif

  nanci_pe_shear #(.SQRT_N(2), .I(0), .PHASES(2)) dut0 (
    .clk(clk), .rst(rst_n), .i_load(ld[0]), .i_elem(elem), .i_start(st[0]),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .o_PE(pe0), .o_busy(busy[0]), .o_done(done[0])
`ifdef NANCI_PE_SWAP_COUNT_EN
    , .o_swaps(sw0)
`endif
  );

  nanci_pe_shear #(.SQRT_N(2), .I(2), .PHASES(2)) dut1 (
    .clk(clk), .rst(rst_n), .i_load(ld[1]), .i_elem(elem), .i_start(st[1]),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .o_PE(pe1), .o_busy(busy[1]), .o_done(done[1])
`ifdef NANCI_PE_SWAP_COUNT_EN
    , .o_swaps(sw1)
`endif
  );

  nanci_pe_shear #(.SQRT_N(1), .I(0), .PHASES(5)) dut2 (
    .clk(clk), .rst(rst_n), .i_load(ld[2]), .i_elem(elem), .i_start(st[2]),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .o_PE(pe2), .o_busy(busy[2]), .o_done(done[2])
`ifdef NANCI_PE_SWAP_COUNT_EN
    , .o_swaps(sw2)
`endif
  );

  nanci_pe_shear #(.SQRT_N(M_N), .I(M_I), .PHASES(M_PH)) dut3 (
    .clk(clk), .rst(rst_n), .i_load(ld[3]), .i_elem(elem), .i_start(st[3]),
    .i_PE_l(pl), .i_PE_r(pr), .i_PE_u(pu), .i_PE_d(pd),
    .o_PE(pe3), .o_busy(busy[3]), .o_done(done[3])
`ifdef NANCI_PE_SWAP_COUNT_EN
    , .o_swaps(sw3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-level model of one exchange on the 4x4 PE; key = data then addr.
  function automatic logic [5:0] ref_step(input logic [5:0] cur, input int k,
                                          input logic [5:0] l, input logic [5:0] r,
                                          input logic [5:0] u, input logic [5:0] d);
    int phase, t, idx, key_c, key_p;
    bit is_row, plus, asc, want_min;
    logic [5:0] p;
    phase  = k / M_N;
    t      = k % M_N;
    is_row = (phase % 2) == 0;
    idx    = is_row ? M_COL : M_ROW;
    plus   = ((idx + t) % 2) == 0;
    if (plus && idx == M_N - 1) return cur;
    if (!plus && idx == 0) return cur;
    if (is_row) p = plus ? r : l;
    else        p = plus ? d : u;
    asc      = !is_row || (M_ROW % 2 == 0);
    want_min = (asc == plus);
    key_c = int'(cur[2:0]) * 8 + int'(cur[5:3]);
    key_p = int'(p[2:0]) * 8 + int'(p[5:3]);
    if (want_min) return (key_p < key_c) ? p : cur;
    return (key_p > key_c) ? p : cur;
  endfunction

  task automatic test_reset();
    n_checks++;
    if ({pe0, pe1, pe2, pe3} !== 24'h0) begin
      n_fail++; $display("FAIL reset_pe: got %h expected 000000", {pe0, pe1, pe2, pe3});
    end
    n_checks++;
    if (busy !== 4'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy);
    end
    n_checks++;
    if (done !== 4'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0000", done);
    end
  endtask

  task automatic test_row_ascending();
    @(negedge clk);
    elem = 6'b000_101; pr = 6'b001_010; ld[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0; st[0] = 1'b0;
    n_checks++;
    if (pe0 !== 6'b000_101) begin
      n_fail++; $display("FAIL row_asc_load: got %b expected 000101", pe0);
    end
    @(negedge clk);
    n_checks++;
    if (pe0 !== 6'b001_010) begin
      n_fail++; $display("FAIL row_asc_min: got %b expected 001010", pe0);
    end
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL row_asc_busy: got %b expected 1", busy[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_row_descending();
    @(negedge clk);
    elem = 6'b000_001; pr = 6'b000_110; ld[1] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    ld[1] = 1'b0; st[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pe1 !== 6'b000_110) begin
      n_fail++; $display("FAIL row_desc_max: got %b expected 000110", pe1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_column_phase();
    logic [5:0] exp_pe [1:5];
    logic       exp_dn [1:5];
    exp_pe = '{6'd5, 6'd5, 6'd1, 6'd1, 6'd1};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    elem = 6'd5; pr = 6'd7; pd = 6'd1; pl = 6'd0; pu = 6'd0;
    ld[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0; st[0] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      n_checks++;
      if (pe0 !== exp_pe[e]) begin
        n_fail++; $display("FAIL col_phase_pe E%0d: got %0d expected %0d", e, pe0, exp_pe[e]);
      end
      n_checks++;
      if (done[0] !== exp_dn[e]) begin
        n_fail++; $display("FAIL col_phase_done E%0d: got %b expected %b", e, done[0], exp_dn[e]);
      end
    end
  endtask

  task automatic test_tie_break();
    logic [5:0] partners [3];
    logic [5:0] expect_v [3];
    partners = '{6'b001_100, 6'b011_100, 6'b101_100};
    expect_v = '{6'b001_100, 6'b011_100, 6'b011_100};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      elem = 6'b011_100; pr = partners[c]; ld[0] = 1'b1; st[0] = 1'b1;
      @(negedge clk);
      ld[0] = 1'b0; st[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pe0 !== expect_v[c]) begin
        n_fail++; $display("FAIL tie_break case %0d: got %b expected %b", c, pe0, expect_v[c]);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_single_pe();
    @(negedge clk);
    elem = 6'b010_011; ld[2] = 1'b1; st[2] = 1'b1;
    @(negedge clk);
    ld[2] = 1'b0; st[2] = 1'b0;
    n_checks++;
    if (busy[2] !== 1'b1) begin
      n_fail++; $display("FAIL single_busy: got %b expected 1", busy[2]);
    end
    for (int e = 1; e <= 6; e++) begin
      ld[2] = (e == 2);
      if (e == 2) elem = 6'b111_000;
      @(negedge clk);
      n_checks++;
      if (pe2 !== 6'b010_011) begin
        n_fail++; $display("FAIL single_pe E%0d: got %b expected 010011", e, pe2);
      end
      n_checks++;
      if (done[2] !== (e == 5)) begin
        n_fail++; $display("FAIL single_done E%0d: got %b expected %b", e, done[2], (e == 5));
      end
    end
    ld[2] = 1'b0;
    n_checks++;
    if (busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy[2]);
    end
  endtask

  task automatic test_random_sort(input int iters);
    logic [5:0] exp_v, l, r, u, d;
    for (int it = 0; it < iters; it++) begin
      @(negedge clk);
      exp_v = 6'($urandom);
      elem = exp_v; ld[3] = 1'b1; st[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pe3 !== exp_v || busy[3] !== 1'b1) begin
        n_fail++; $display("FAIL rand_start it%0d: got pe=%b busy=%b expected pe=%b busy=1", it, pe3, busy[3], exp_v);
      end
      for (int k = 0; k < M_K; k++) begin
        l = 6'($urandom); r = 6'($urandom); u = 6'($urandom); d = 6'($urandom);
        pl = l; pr = r; pu = u; pd = d;
        ld[3] = 1'($urandom); st[3] = 1'($urandom); elem = 6'($urandom);
        @(negedge clk);
        exp_v = ref_step(exp_v, k, l, r, u, d);
        n_checks++;
        if (pe3 !== exp_v) begin
          n_fail++; $display("FAIL rand_pe it%0d E%0d: got %b expected %b", it, k + 1, pe3, exp_v);
        end
        n_checks++;
        if (busy[3] !== (k < M_K - 1) || done[3] !== (k == M_K - 1)) begin
          n_fail++; $display("FAIL rand_flags it%0d E%0d: got busy=%b done=%b expected busy=%b done=%b",
                             it, k + 1, busy[3], done[3], (k < M_K - 1), (k == M_K - 1));
        end
      end
      ld[3] = 1'($urandom); st[3] = 1'($urandom); elem = 6'($urandom);
      @(negedge clk);
      ld[3] = 1'b0; st[3] = 1'b0;
      n_checks++;
      if (pe3 !== exp_v || done[3] !== 1'b0 || busy[3] !== 1'b0) begin
        n_fail++; $display("FAIL rand_after_done it%0d: got pe=%b done=%b busy=%b expected pe=%b done=0 busy=0",
                           it, pe3, done[3], busy[3], exp_v);
      end
    end
  endtask

  task automatic test_reset_midsort();
    @(negedge clk);
    elem = 6'b110_111; ld[3] = 1'b1; st[3] = 1'b1;
    @(negedge clk);
    ld[3] = 1'b0; st[3] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pe3 !== 6'b0 || busy[3] !== 1'b0 || done[3] !== 1'b0) begin
      n_fail++; $display("FAIL midsort_reset: got pe=%b busy=%b done=%b expected all zero", pe3, busy[3], done[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_random_sort(1);
  endtask

  initial begin
    rst_n = 1'b0;
    ld = '0; st = '0; elem = '0;
    pl = '0; pr = '0; pu = '0; pd = '0;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_row_ascending();
    test_row_descending();
    test_column_phase();
    test_tie_break();
    test_single_pe();
    test_random_sort(25);
    test_reset_midsort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nanci_pe_shear.md
Name: nanci_pe_shear

Overview:
- Parametrised successor to the single-step mesh PE.
- One processing element of a SQRT_N x SQRT_N Nanci mesh.
- Holds one packed element {addr, data} and runs a complete shearsort autonomously after a broadcast start: alternating snake-order row phases and ascending column phases of odd-even transposition.
- All PEs in the mesh run in lock-step. Each exchange uses the neighbours' registered o_PE.

Parameters:
- SQRT_N, 4, mesh side length (>=1); N = SQRT_N*SQRT_N.
- I, 0, linear PE index; row = I / SQRT_N, col = I % SQRT_N.
- ADDR_WIDTH, 3, tag width (upper field of element).
- DATA_WIDTH, 3, key width (lower field of element).
- PHASES, 5, total phases. Even phase index = row phase, odd = column phase.
- STEP_W, 8, width of internal step/phase counters.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- i_load, input, 1, load i_elem into the element register (honoured only in IDLE).
- i_elem, input, ADDR_WIDTH+DATA_WIDTH, element to load.
- i_start, input, 1, start a sort (honoured only in IDLE).
- i_PE_l / i_PE_r / i_PE_u / i_PE_d, input, ADDR_WIDTH+DATA_WIDTH each, neighbour o_PE values.
- o_PE, output, ADDR_WIDTH+DATA_WIDTH, registered element.
- o_busy, output, 1, high in ROW or COL.
- o_done, output, 1, one-cycle pulse at sort completion.

Behaviour:
- Reset (rst low, asynchronous):
  - o_PE=0, o_busy=0, o_done=0.
  - State IDLE; step and phase counters = 0.
  - A reset mid-sort aborts immediately; the element is lost.
- States: IDLE, ROW, COL, DONE.
- IDLE:
  - i_load=1 writes i_elem to o_PE at the edge.
  - i_start=1 moves to ROW with phase=0, step=0.
  - If both are high, the load is written and the sort starts on the loaded value.
- ROW/COL, one exchange per clock edge, counter t = step within phase:
  - idx = col in ROW, row in COL.
  - Partner: +1 neighbour (r in ROW, d in COL) if (idx+t) is even, else -1 neighbour (l or u).
  - Out-of-range partner (idx=0 going -1, idx=SQRT_N-1 going +1): hold the value.
- Order:
  - Ascending in COL and in ROW for even rows; descending in ROW for odd rows (snake).
  - Ascending with partner +1: keep min. Ascending with partner -1: keep max. Descending inverts this.
- Compare rule:
  - Unsigned data decides.
  - Equal data: smaller addr is "min".
  - Fully equal elements: no change.
- Counters:
  - t increments per edge. At t=SQRT_N-1, t wraps to 0 and phase increments.
  - Next state is ROW/COL by phase parity.
  - After the last step of phase PHASES-1, go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy is low in DONE and IDLE.
- Latency:
  - Start sampled at edge E0; exchanges occur at edges E1..EK, K = PHASES*SQRT_N.
  - o_done is high from EK to EK+1.
- i_load and i_start are ignored while busy or in DONE.
- SQRT_N=1: every partner is out of range, so the value is unchanged and o_done follows after PHASES edges.

Optional Feature:
- Macro: NANCI_PE_SWAP_COUNT_EN.
- Defined:
  - Extra output o_swaps, STEP_W bits.
  - Cleared on reset and on an accepted i_start.
  - Increments on every edge where o_PE changes during ROW/COL; saturates at all-ones.
- Undefined: port absent, no counter logic.

Decomposition:
- Package nanci_pkg:
  - element width function/localparam.
  - state enum {IDLE, ROW, COL, DONE}.
  - partner-direction enum {L, R, U, D, NONE}.
  - element field-extract helpers.
- One natural sub-module: nanci_cx_unit. Combinational compare-exchange taking own element, partner element and keep_min, returning the kept element with the tie-break. The PE instantiates it once after muxing the partner.

Test Plan:
1. SQRT_N=2, I=0, load {000,101}, i_PE_r={001,010}, start → after E1 o_PE={001,010}; o_busy=1.
2. SQRT_N=2, I=2 (row 1, descending), load {000,001}, i_PE_r={000,110}, start → after E1 o_PE={000,110} (keeps max).
3. Column phase: SQRT_N=2, PHASES=2, I=0, load 5, i_PE_r=7, i_PE_d=1 → row step 0 keeps 5; phase 1, t=0 partner d → o_PE data=1; o_done pulse at E4.
4. Tie-break: own {011,100}, i_PE_r={001,100}, I=0 ascending → o_PE={001,100}; with i_PE_r={011,100} → unchanged.
5. SQRT_N=1, PHASES=5, load {010,011}, start → o_PE stays 3; o_done high exactly E5–E6; i_load asserted at E2 is ignored.
6. Reset mid-sort: assert rst low between E2 and E3 → o_PE=0, o_busy=0 immediately (asynchronous); after release, i_start restarts cleanly.
